// File: rtl/pid_scheduler_if.sv
// Handshake and data bundle between a client and the time-shared PID scheduler.
interface pid_scheduler_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = $clog2(N_CH);

  logic                   enable;
  logic                   clear;
  logic [N_CH-1:0]        req;
  logic [16*N_CH-1:0]     refer;
  logic [16*N_CH-1:0]     data;
  logic [N_CH-1:0]        ack;
  logic signed [15:0]     control;
  logic                   ctrl_valid;
  logic [CH_W-1:0]        ctrl_ch;
  logic                   busy;

  modport master (
    output enable, clear, req, refer, data,
    input  ack, control, ctrl_valid, ctrl_ch, busy
  );

  modport slave (
    input  enable, clear, req, refer, data,
    output ack, control, ctrl_valid, ctrl_ch, busy
  );
endinterface

// File: rtl/pid_scheduler.sv
// Round-robin PID controller sharing one multiplier/accumulator across N_CH channels.
// Each grant runs LOAD, MAC_P, MAC_I, MAC_D, DONE: one result every five cycles.
module pid_scheduler #(
  parameter int N_CH  = 4,
  parameter int KP    = 922,
  parameter int KI    = 922,
  parameter int KD    = 922,
  parameter int I_MAX = 2147483647
) (
  input  logic            clk,
  input  logic            reset,
  pid_scheduler_if.slave  bus
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int CH_W   = $clog2(N_CH);
  localparam int PROD_W = 32 + COEF_W;
  localparam int ACC_W  = 50;

  localparam logic signed [COEF_W-1:0] KP_C = COEF_W'(KP);
  localparam logic signed [COEF_W-1:0] KI_C = COEF_W'(KI);
  localparam logic signed [COEF_W-1:0] KD_C = COEF_W'(KD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC_P = 3'd2,
    MAC_I = 3'd3,
    MAC_D = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [N_CH-1:0]  pending, pend_eff, pend_nx;
  logic [CH_W-1:0]  last_grant, grant, arb_idx, scan_idx;
  logic             arb_found, grant_go;
  logic [N_CH-1:0]  grant_oh;

  logic signed [31:0] prev_err [N_CH];
  logic signed [31:0] prev_int [N_CH];

  logic signed [DATA_W-1:0] ref_s, dat_s;
  logic signed [DATA_W:0]   diff17;
  logic signed [31:0]       err_ld;

  logic signed [31:0]       err_p0, int_p0, der_p0;
  logic signed [ACC_W-1:0]  acc_p1, acc_nx;
  logic signed [31:0]       mul_a;
  logic signed [COEF_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;

  logic signed [15:0] control_q;
  logic [CH_W-1:0]    ctrl_ch_q;

  // Arithmetic shift by the Q10 point, then clamp to the 16-bit output range.
  function automatic logic signed [15:0] sat_ctrl(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> 10;
    if (s > 50'sd32767)
      sat_ctrl = 16'sh7fff;
    else if (s < -50'sd32768)
      sat_ctrl = 16'sh8000;
    else
      sat_ctrl = s[15:0];
  endfunction

  // Stored integral is kept non-negative and bounded above by I_MAX.
  function automatic logic signed [31:0] clamp_int(input logic signed [31:0] v);
    if (v < 32'sd0)
      clamp_int = 32'sd0;
    else if (v > I_MAX)
      clamp_int = I_MAX;
    else
      clamp_int = v;
  endfunction

  assign pend_eff = pending | bus.req;
  assign grant_oh = {{(N_CH-1){1'b0}}, 1'b1} << grant;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      scan_idx = CH_W'((int'(last_grant) + k) % N_CH);
      if (!arb_found && pend_eff[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  assign grant_go = ((state == IDLE) || (state == DONE)) && bus.enable && arb_found;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_go) state_nx = LOAD;
      LOAD:    state_nx = MAC_P;
      MAC_P:   state_nx = MAC_I;
      MAC_I:   state_nx = MAC_D;
      MAC_D:   state_nx = DONE;
      DONE:    state_nx = grant_go ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A request arriving in the same cycle as LOAD's clear re-arms its bit.
  always_comb begin
    pend_nx = pending | bus.req;
    if (state == LOAD)
      pend_nx = (pending & ~grant_oh) | bus.req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= CH_W'(N_CH - 1);
      grant      <= '0;
      control_q  <= '0;
      ctrl_ch_q  <= '0;
    end else begin
      state   <= state_nx;
      pending <= pend_nx;
      if (grant_go) begin
        grant      <= arb_idx;
        last_grant <= arb_idx;
      end
      if (state == MAC_D) begin
        control_q <= sat_ctrl(acc_nx);
        ctrl_ch_q <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      for (int k = 0; k < N_CH; k++) begin
        prev_err[k] <= '0;
        prev_int[k] <= '0;
      end
    end else if (state == DONE) begin
      prev_err[grant] <= err_p0;
      prev_int[grant] <= clamp_int(int_p0);
    end
  end

  // Stage p0: sample the granted channel and form error, integral and derivative terms.
  always_comb begin
    ref_s  = bus.refer[DATA_W*int'(grant) +: DATA_W];
    dat_s  = bus.data[DATA_W*int'(grant) +: DATA_W];
    diff17 = {ref_s[DATA_W-1], ref_s} - {dat_s[DATA_W-1], dat_s};
    err_ld = {{(32-DATA_W-1){diff17[DATA_W]}}, diff17};
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      err_p0 <= err_ld;
      int_p0 <= err_ld + prev_int[grant];
      der_p0 <= err_ld - prev_err[grant];
    end
  end

  // Stage p1: shared multiplier feeding the accumulator over three MAC cycles.
  always_comb begin
    mul_a = err_p0;
    mul_b = KP_C;
    case (state)
      MAC_I: begin
        mul_a = int_p0;
        mul_b = KI_C;
      end
      MAC_D: begin
        mul_a = der_p0;
        mul_b = KD_C;
      end
      default: ;
    endcase
    prod = mul_a * mul_b;
    if (state == MAC_P)
      acc_nx = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    else
      acc_nx = acc_p1 + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if ((state == MAC_P) || (state == MAC_I) || (state == MAC_D))
      acc_p1 <= acc_nx;
  end

  assign bus.ack        = (state == LOAD) ? grant_oh : '0;
  assign bus.ctrl_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.control    = control_q;
  assign bus.ctrl_ch    = ctrl_ch_q;

endmodule

// File: tb/tb_pid_scheduler.sv
// Directed bench for pid_scheduler with unity Q10 gains and hand-computed results.
module tb_pid_scheduler;

  localparam int NCH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pid_scheduler_if #(.N_CH(NCH)) bus ();

  pid_scheduler #(
    .N_CH (NCH),
    .KP   (1024),
    .KI   (1024),
    .KD   (1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int r, input int d);
    bus.refer[16*ch +: 16] = 16'(r);
    bus.data[16*ch +: 16]  = 16'(d);
  endtask

  // One request from IDLE: ack one cycle later, result five cycles later.
  task automatic serve(input string tag, input int ch, input int exp_ctrl);
    bus.req = NCH'(1 << ch);
    step();
    bus.req = '0;
    chk({tag, "_ack"}, bus.ack, 1 << ch);
    chk({tag, "_busy"}, bus.busy, 1);
    repeat (3) step();
    chk({tag, "_early_valid"}, bus.ctrl_valid, 0);
    step();
    chk({tag, "_valid"}, bus.ctrl_valid, 1);
    chk({tag, "_ch"}, bus.ctrl_ch, ch);
    chk({tag, "_control"}, bus.control, exp_ctrl);
    step();
    chk({tag, "_valid_drop"}, bus.ctrl_valid, 0);
    chk({tag, "_hold"}, bus.control, exp_ctrl);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.clear  = 1'b0;
    bus.req    = '0;
    bus.refer  = '0;
    bus.data   = '0;
    step();
    step();

    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.ctrl_valid, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_control", bus.control, 0);
    chk("rst_ch", bus.ctrl_ch, 0);
    reset = 1'b0;
    repeat (3) step();
    chk("idle_busy", bus.busy, 0);
    chk("idle_control", bus.control, 0);

    // err=60, I=60, D=60; then I=120, D=0; then err=0, I=120, D=-60.
    set_ch(0, 100, 40);
    serve("single", 0, 180);
    serve("history", 0, 180);
    set_ch(0, 0, 0);
    serve("hist_probe", 0, 60);

    // Saturating output; after clear, negative integral is stored as 0.
    set_ch(1, 32767, -32768);
    serve("sat", 1, 32767);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    set_ch(1, 0, 50);
    serve("neg", 1, -150);
    set_ch(1, 0, 0);
    serve("iclamp_probe", 1, 50);

    // Round-robin from a fresh reset: all four requested in one cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NCH; i++) set_ch(i, 10 * (i + 1), 0);
    bus.req = '1;
    step();
    bus.req = '0;
    for (int k = 1; k <= 20; k++) begin
      chk("rr_busy", bus.busy, 1);
      chk("rr_valid", bus.ctrl_valid, (k % 5 == 0) ? 1 : 0);
      if (k % 5 == 1) chk("rr_ack", bus.ack, 1 << (k / 5));
      if (k % 5 == 0) begin
        chk("rr_ch", bus.ctrl_ch, k / 5 - 1);
        chk("rr_control", bus.control, 30 * (k / 5));
      end
      if (k < 20) step();
    end
    step();
    chk("rr_idle", bus.busy, 0);

    // Build ch0 history with prev_int != prev_error, then abort a run in MAC_I.
    set_ch(0, 30, 0);
    serve("pre_abort", 0, 90);
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.ctrl_valid, 0);
    chk("abort_ack", bus.ack, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("abort_no_valid", bus.ctrl_valid, 0);
      chk("abort_control", bus.control, 0);
    end
    set_ch(0, 5, 0);
    serve("abort_probe", 0, 15);

    // Clear asserted in the DONE cycle beats the writeback.
    set_ch(2, 50, 0);
    serve("c2_first", 2, 150);
    bus.req = 4'b0100;
    step();
    bus.req = '0;
    repeat (4) step();
    chk("c2_done_valid", bus.ctrl_valid, 1);
    chk("c2_done_control", bus.control, 150);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;

    // Enable gating, then a grant; refer changes after LOAD must be ignored.
    set_ch(2, 5, 0);
    bus.enable = 1'b0;
    bus.req    = 4'b0100;
    step();
    bus.req = '0;
    for (int k = 0; k < 3; k++) begin
      chk("gate_ack", bus.ack, 0);
      chk("gate_busy", bus.busy, 0);
      step();
    end
    bus.enable = 1'b1;
    step();
    chk("en_ack", bus.ack, 4);
    step();
    set_ch(2, 1000, -1000);
    repeat (2) step();
    chk("en_early_valid", bus.ctrl_valid, 0);
    step();
    chk("en_valid", bus.ctrl_valid, 1);
    chk("en_ch", bus.ctrl_ch, 2);
    chk("en_control", bus.control, 15);
    step();
    chk("en_end", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_scheduler.md
PID_SCHEDULER -- requirements
Module: pid_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_CH, 4: number of control channels, 2..16.
- KP, 922: proportional gain, signed Q10 integer, -32768..32767.
- KI, 922: integral gain, signed Q10.
- KD, 922: derivative gain, signed Q10.
- I_MAX, 2147483647: upper clamp for the stored integral.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high reset, sampled on the clk rising edge.
- enable, in, 1: permits new grants.
- clear, in, 1: zeroes all channel history.
- req, in, N_CH: per-channel compute request pulses.
- refer, in, 16*N_CH: signed setpoint; channel i occupies bits [16i+15:16i].
- data, in, 16*N_CH: signed measurement, same packing as refer.
- ack, out, N_CH: one-hot, high for one cycle when a channel's inputs are sampled.
- control, out, 16: signed, saturated controller output.
- ctrl_valid, out, 1: single-cycle strobe marking control and ctrl_ch as valid.
- ctrl_ch, out, clog2(N_CH): channel index of the current control value.
- busy, out, 1: high whenever state is not IDLE.

Function
REQ-003 The block SHALL time-share one multiplier and one accumulator across N_CH channels, keeping prev_error[i] and prev_int[i] (32-bit signed) for each channel.
REQ-004 Request capture:
- req[i]=1 SHALL set pending[i].
- LOAD SHALL clear pending[] only for the granted channel.
- If a req and a clear hit the same bit in the same cycle, set SHALL win.
REQ-005 Arbitration SHALL be round-robin: search pending[] starting at last_grant+1, wrapping at N_CH; last_grant SHALL reset to N_CH-1 so channel 0 wins first.
REQ-006 The FSM states SHALL be IDLE, LOAD, MAC_P, MAC_I, MAC_D, DONE, with these transitions:
- IDLE to LOAD when enable=1 and pending!=0; otherwise stay in IDLE.
- LOAD to MAC_P to MAC_I to MAC_D to DONE, unconditionally.
- DONE to LOAD when enable=1 and pending!=0 (back-to-back service); otherwise DONE to IDLE.
REQ-007 On entry to LOAD, the block SHALL latch the grant index.
REQ-008 In the LOAD cycle:
- ack[grant] SHALL be 1.
- The block SHALL register err = sext32(refer[g]) - sext32(data[g]), computed at 17-bit precision and sign-extended.
- The block SHALL register I = err + prev_int[g] and D = err - prev_error[g], both 32-bit wrapping.
REQ-009 Accumulation:
- MAC_P SHALL load acc = err*KP.
- MAC_I SHALL add I*KI to acc.
- MAC_D SHALL add D*KD to acc.
- acc SHALL be 50-bit signed, and products 48-bit signed.
REQ-010 In DONE, control SHALL equal sat16(acc >>>10), an arithmetic shift clamped to -32768..32767; ctrl_valid SHALL be 1 and ctrl_ch SHALL equal the grant index.
REQ-011 control and ctrl_ch SHALL hold their values until the next DONE; ctrl_valid SHALL be 0 outside DONE.
REQ-012 Latency: a request seen in IDLE at cycle t SHALL produce ctrl_valid at cycle t+5; back-to-back service throughput SHALL be one result per 5 cycles.
REQ-013 Writeback in DONE:
- prev_error[g] SHALL be set to err.
- prev_int[g] SHALL be set to 0 if I<0, to I_MAX if I>I_MAX, and to I otherwise.
REQ-014 enable=0 SHALL block new grants only; an in-flight computation SHALL complete, and pending bits SHALL keep accumulating.
REQ-015 clear=1 SHALL zero all prev_error and prev_int in that cycle, with priority over a DONE writeback in the same cycle; it SHALL NOT affect pending, the FSM state, or an in-flight acc.
REQ-016 refer and data SHALL be sampled only in the LOAD cycle; changes at any other time SHALL be ignored.

Reset
REQ-017 While reset=1, the block SHALL set:
- state to IDLE;
- pending, all prev_error and all prev_int to 0;
- last_grant to N_CH-1;
- control to 0, ctrl_ch to 0, and ctrl_valid, ack and busy to 0.
REQ-018 Reset SHALL override every other input, including reset asserted mid-computation: the result is discarded and no writeback occurs.
REQ-019 After reset deasserts, no output SHALL change until the first grant.

Verification
REQ-020 The bench SHALL cover these directed scenarios (KP=KI=KD=1024, I_MAX default):
- Single request: ch0 refer=100, data=40, req at cycle t -> ack[0] at t+1, ctrl_valid at t+5, control=180.
- History: repeat the single-request stimulus on ch0 -> control=180 (err=60, I=120, D=0), after which prev_int[0]=120.
- Saturation and integral clamp: ch1 refer=32767, data=-32768 -> control=32767. Then ch1 refer=0, data=50 after clear -> control=-150 and prev_int[1]=0.
- Round-robin: req=4'b1111 in one cycle -> ctrl_ch sequence 0,1,2,3, with ctrl_valid at t+5, t+10, t+15, t+20 and busy continuously high.
- Reset and clear mid-operation: reset asserted in MAC_I -> the next cycle is IDLE with no ctrl_valid and prev arrays zero. clear asserted in DONE -> the ch history reads 0 afterwards.
- Enable gating: enable=0 with req[2] pulsed -> no ack. Raising enable -> ack[2] on the next cycle and the result 4 cycles later.
